// File: rtl/uart_rx_8.sv
// 8-bit UART receiver: 8N1 frames, data MSB first, oversampled on clk.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote around every sample point.
`timescale 1ns/1ps
module uart_rx_8 #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_byte,
  output logic       data_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] CNT_MID  = 16'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_MAJORITY_EN
  // Start decision lands one cycle late; later bit decisions at CNT_LAST stay
  // on centre+1 because the whole timeline is shifted by that same cycle.
  localparam logic [15:0] START_PT = CNT_MID + 16'd1;
`else
  localparam logic [15:0] START_PT = CNT_MID;
`endif

  logic        sync1_q, rx_s_q;
  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bidx_q, bidx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        bit_val;

`ifdef UART_RX_MAJORITY_EN
  logic samp_old_q, samp_new_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_old_q <= 1'b1;
      samp_new_q <= 1'b1;
    end else begin
      samp_old_q <= samp_new_q;
      samp_new_q <= rx_s_q;
    end
  end

  always_comb begin
    bit_val = (samp_old_q & samp_new_q) | (samp_old_q & rx_s_q) |
              (samp_new_q & rx_s_q);
  end
`else
  always_comb begin
    bit_val = rx_s_q;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (cnt_q == START_PT) begin
          cnt_d = '0;
          if (bit_val) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = S_DATA;
            bidx_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {shreg_q[6:0], bit_val};
          bidx_d  = bidx_q + 3'd1;
          if (bidx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          busy_d  = 1'b0;
          if (bit_val) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign data_byte  = data_q;
  assign data_valid = valid_q;
  assign frame_err  = err_q;
  assign rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_8.sv
// Self-checking bench for uart_rx_8 (CLKS_PER_BIT=16): vector table, corner
// sequences and randomized frames against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_8;

  localparam int unsigned CPB     = 16;
  localparam int unsigned MID     = CPB / 2 - 1;
  localparam int          LAT_EXP = 2 + MID + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data_byte;
  logic       data_valid;
  logic       frame_err;
  logic       rx_busy;

  uart_rx_8 #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data_byte (data_byte),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       err;
    logic [7:0] d;
    int         cyc;
  } ev_t;

  ev_t obs[$];
  int  overlap = 0;

  always @(negedge clk) begin
    if (data_valid && frame_err) overlap++;
    if (data_valid) obs.push_back('{1'b0, data_byte, cyc});
    if (frame_err)  obs.push_back('{1'b1, data_byte, cyc});
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic busy_mid;

  // One 8N1 frame, data MSB first; spike inverts rx for one clk at each bit centre.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic spike,
                            output int t0);
    logic v;
    t0 = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      v = 1'b0;
      else if (k == 9) v = stop;
      else             v = b[8 - k];
      for (int c = 0; c < int'(CPB); c++) begin
        @(negedge clk);
        rx = (spike && c == int'(CPB / 2)) ? ~v : v;
        if (k == 0 && c == 0) t0 = cyc;
        if (k == 5 && c == 0) busy_mid = rx_busy;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  int         t0, nv, ne;
  logic [7:0] model_byte;
  logic       saw_busy;

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", {data_byte, data_valid, frame_err, rx_busy}, 32'h0);
    reset = 1'b0;
    idle(10);

    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h5A, 1'b0, 0, 1, 8'hA5};
    vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[4] = '{8'h5A, 1'b0, 0, 1, 8'hFF};
    vecs[5] = '{8'hC3, 1'b1, 1, 0, 8'hC3};

    for (int i = 0; i < 6; i++) begin
      obs.delete();
      send_frame(vecs[i].b, vecs[i].stop, 1'b0, t0);
      idle(20);
      nv = 0;
      ne = 0;
      foreach (obs[j]) begin
        if (obs[j].err) ne++;
        else            nv++;
      end
      check($sformatf("vec%0d_valid_cnt", i), nv, vecs[i].exp_valid);
      check($sformatf("vec%0d_err_cnt", i), ne, vecs[i].exp_err);
      check($sformatf("vec%0d_data", i), data_byte, vecs[i].exp_data);
      check($sformatf("vec%0d_busy_mid", i), busy_mid, 1'b1);
      check($sformatf("vec%0d_busy_end", i), rx_busy, 1'b0);
      if (i == 0 && obs.size() == 1) begin
        check("latency_ok", (obs[0].cyc - t0 >= LAT_EXP) && (obs[0].cyc - t0 <= LAT_EXP + 2), 1'b1);
      end
    end

    // Back-to-back frames, no idle gap
    obs.delete();
    send_frame(8'h00, 1'b1, 1'b0, t0);
    send_frame(8'hFF, 1'b1, 1'b0, t0);
    send_frame(8'h3C, 1'b1, 1'b0, t0);
    idle(20);
    check("b2b_count", obs.size(), 3);
    if (obs.size() == 3) begin
      check("b2b_d0", {obs[0].err, obs[0].d}, {1'b0, 8'h00});
      check("b2b_d1", {obs[1].err, obs[1].d}, {1'b0, 8'hFF});
      check("b2b_d2", {obs[2].err, obs[2].d}, {1'b0, 8'h3C});
      check("b2b_gap01", (obs[1].cyc - obs[0].cyc >= 159) && (obs[1].cyc - obs[0].cyc <= 161), 1'b1);
      check("b2b_gap12", (obs[2].cyc - obs[1].cyc >= 159) && (obs[2].cyc - obs[1].cyc <= 161), 1'b1);
    end

    // 4-clk glitch on idle line
    obs.delete();
    saw_busy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      rx = 1'b0;
    end
    repeat (10) begin
      @(negedge clk);
      rx = 1'b1;
      if (rx_busy) saw_busy = 1'b1;
    end
    check("glitch_busy_seen", saw_busy, 1'b1);
    check("glitch_busy_clear", rx_busy, 1'b0);
    idle(40);
    check("glitch_no_pulse", obs.size(), 0);

    // Reset in the middle of a frame carrying C3
    obs.delete();
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < int'(CPB); c++) begin
        logic [7:0] cb;
        cb = 8'hC3;
        @(negedge clk);
        rx = (k == 0) ? 1'b0 : cb[8 - k];
      end
    end
    @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    #2;
    check("reset_async", {data_byte, data_valid, frame_err, rx_busy}, 32'h0);
    repeat (5) @(negedge clk);
    check("reset_hold", {data_byte, data_valid, frame_err, rx_busy}, 32'h0);
    reset = 1'b0;
    idle(30);
    send_frame(8'h81, 1'b1, 1'b0, t0);
    idle(20);
    check("post_reset_count", obs.size(), 1);
    if (obs.size() == 1) check("post_reset_byte", {obs[0].err, obs[0].d}, {1'b0, 8'h81});
    check("post_reset_data", data_byte, 8'h81);

    // 0x96, spiked at each bit centre only when majority voting is built in
    obs.delete();
`ifdef UART_RX_MAJORITY_EN
    send_frame(8'h96, 1'b1, 1'b1, t0);
`else
    send_frame(8'h96, 1'b1, 1'b0, t0);
`endif
    idle(20);
    check("b96_count", obs.size(), 1);
    check("b96_data", data_byte, 8'h96);

    // Randomized frames against a frame-level model
    model_byte = 8'h96;
    for (int i = 0; i < 30; i++) begin
      logic [7:0] b;
      logic       stop;
      int         gap;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      gap  = stop ? int'($urandom_range(0, 6)) : int'($urandom_range(12, 20));
      obs.delete();
      send_frame(b, stop, 1'b0, t0);
      idle(gap);
      if (stop) model_byte = b;
      check($sformatf("rnd%0d_count", i), obs.size(), 1);
      if (obs.size() == 1) begin
        check($sformatf("rnd%0d_kind", i), obs[0].err, !stop);
        if (stop) check($sformatf("rnd%0d_byte", i), obs[0].d, b);
      end
      check($sformatf("rnd%0d_hold", i), data_byte, model_byte);
    end
    idle(20);

    check("valid_err_exclusive", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
